even_parity_framer: RTL and testbench

- Upstream stage of the even-parity checker.
- Accepts parallel data words on a valid/ready handshake and appends an even parity bit (XOR of all data bits).
- Emits each frame two ways:
  - bit-serially, LSB first, followed by the parity bit;
  - as a registered parallel word+parity strobe that feeds the checker's data and P inputs directly.
- Default width matches the checker's three data inputs plus one parity input.

---
 rtl/parity_pkg.sv | 8 +
 rtl/even_parity_framer.sv | 74 +++++++
 tb/tb_even_parity_framer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// parity_pkg: framer FSM encoding and even-parity helper shared with the checker side
package parity_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY} framer_state_t;
    localparam logic PARITY_EVEN = 1'b0;
    function automatic logic even_parity(input logic [31:0] data);
        return PARITY_EVEN ^ (^data);
    endfunction
endpackage

// File: rtl/even_parity_framer.sv
// even_parity_framer: frames words with an even parity bit, serial (LSB first) and parallel.
// Define PARITY_ERR_INJECT_EN to add err_inject/err_injected for forcing odd parity on a frame.
module even_parity_framer
    import parity_pkg::*;
#(
    parameter int DATA_W = 3,
    localparam int CNT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_last,
    output logic [DATA_W-1:0] par_data,
    output logic              par_p,
    output logic              par_valid,
    output logic              busy
`ifdef PARITY_ERR_INJECT_EN
    ,
    input  logic              err_inject,
    output logic              err_injected
`endif
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
    framer_state_t state, state_nx;
    logic [DATA_W-1:0] shift;
    logic [CNT_W-1:0] cnt;
    logic parity, accept, p_nx;
    assign accept = in_valid && in_ready;
`ifdef PARITY_ERR_INJECT_EN
    assign p_nx = even_parity(32'(in_data)) ^ err_inject;
    always_ff @(posedge clk)
        err_injected <= !rst && accept && err_inject;
`else
    assign p_nx = even_parity(32'(in_data));
`endif
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;
    // IDLE and PARITY share the same exit: a new word restarts DATA, otherwise go idle
    always_comb
        state_nx = (state == DATA) ? ((cnt == LAST) ? PARITY : DATA) : (accept ? DATA : IDLE);
    always_comb begin
        in_ready  = !rst && (state == IDLE || state == PARITY);
        ser_valid = state == DATA || state == PARITY;
        ser_last  = state == PARITY;
        ser_out   = (state == DATA) ? shift[0] : (state == PARITY) && parity;
        busy      = state != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            shift     <= '0;
            cnt       <= '0;
            parity    <= 1'b0;
            par_data  <= '0;
            par_p     <= 1'b0;
            par_valid <= 1'b0;
        end else begin
            par_valid <= accept;
            if (accept) begin
                shift    <= in_data;
                parity   <= p_nx;
                cnt      <= '0;
                par_data <= in_data;
                par_p    <= p_nx;
            end else if (state == DATA) begin
                shift <= shift >> 1;
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_even_parity_framer.sv
// tb_even_parity_framer: scoreboard bench; a cycle model pushes expected serial bits and
// parallel words at accept and pops them as the framer emits them.
module tb_even_parity_framer;
    localparam int W = 3;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic in_ready, ser_out, ser_valid, ser_last, par_p, par_valid, busy;
    logic [W-1:0] par_data;
`ifdef PARITY_ERR_INJECT_EN
    logic err_inject = 1'b0, err_injected;
`endif
    even_parity_framer #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .ser_out(ser_out), .ser_valid(ser_valid), .ser_last(ser_last),
        .par_data(par_data), .par_p(par_p), .par_valid(par_valid), .busy(busy)
`ifdef PARITY_ERR_INJECT_EN
        , .err_inject(err_inject), .err_injected(err_injected)
`endif
    );
    always #5 clk = ~clk;
    int n_chk = 0, n_pass = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask
    logic [1:0] ser_q[$];
    logic [W+1:0] par_q[$];
    int phase = 0;
    logic par_due = 1'b0, took = 1'b0;
    always @(negedge clk) begin
        logic exp_ready, acc, p, inj;
        logic [1:0] sb;
        logic [W+1:0] pe;
        exp_ready = !rst && (phase == 0 || phase == W + 1);
        chk("in_ready", in_ready, exp_ready);
        chk("busy", busy, phase != 0);
        chk("ser_valid", ser_valid, phase != 0);
        if (phase != 0) begin
            if (ser_q.size() == 0) chk("ser_underflow", 1, 0);
            else begin
                sb = ser_q.pop_front();
                chk("ser_out", ser_out, sb[1]);
                chk("ser_last", ser_last, sb[0]);
            end
        end else begin
            chk("ser_out_idle", ser_out, 0);
            chk("ser_last_idle", ser_last, 0);
        end
        chk("par_valid", par_valid, par_due);
        if (par_due && par_q.size() != 0) begin
            pe = par_q.pop_front();
            chk("par_data", par_data, pe[W+1:2]);
            chk("par_p", par_p, pe[1]);
            chk("checker_err", ^{par_data, par_p}, pe[0]);
`ifdef PARITY_ERR_INJECT_EN
            chk("err_injected", err_injected, pe[0]);
        end else begin
            chk("err_injected_idle", err_injected, 0);
`endif
        end
        inj = 1'b0;
`ifdef PARITY_ERR_INJECT_EN
        inj = err_inject;
`endif
        acc = in_valid && exp_ready;
        took = acc;
        if (rst) begin
            ser_q.delete();
            par_q.delete();
            phase = 0;
            par_due = 1'b0;
        end else begin
            if (acc) begin
                p = (^in_data) ^ inj;
                for (int k = 0; k < W; k++) ser_q.push_back({in_data[k], 1'b0});
                ser_q.push_back({p, 1'b1});
                par_q.push_back({in_data, p, inj});
            end
            par_due = acc;
            phase = acc ? 1 : (phase >= 1 && phase <= W) ? phase + 1 : 0;
        end
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [W-1:0] d);
        int n;
        in_valid = 1'b1;
        in_data = d;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!took && n < 20);
        if (!took) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask
    task automatic wait_idle();
        int n;
        n = 0;
        while (phase != 0 && n < 50) begin
            tick(1);
            n++;
        end
        if (phase != 0) chk("idle_timeout", 0, 1);
    endtask
    initial begin
        tick(3);
        chk("rst_par_data", par_data, 0);
        chk("rst_par_p", par_p, 0);
        rst = 1'b0;
        send(3'b101);
        wait_idle();
        send(3'b111);
        wait_idle();
        send(3'b001);
        send(3'b110);
        send(3'b000);
        wait_idle();
        send(3'b010);
        tick(1);
        in_valid = 1'b1;
        in_data = 3'b111;
        tick(1);
        in_valid = 1'b0;
        wait_idle();
        send(3'b011);
        tick(1);
        rst = 1'b1;
        tick(2);
        chk("midrst_par_data", par_data, 0);
        chk("midrst_par_p", par_p, 0);
        rst = 1'b0;
        tick(2);
`ifdef PARITY_ERR_INJECT_EN
        err_inject = 1'b1;
        send(3'b100);
        err_inject = 1'b0;
        send(3'b100);
        wait_idle();
`endif
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 1) tick($urandom_range(0, 3));
            send(W'($urandom_range(0, 7)));
        end
        wait_idle();
        tick(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
